// File: rtl/rob_pkg.sv
// Shared constants and instruction-kind encodings for the reorder buffer.
// Default entry-count exponent lives here so every file agrees on it.
package rob_pkg;

  localparam int ROB_BIT_DEF  = 3;
  localparam int ROB_SIZE_DEF = 2 ** ROB_BIT_DEF;
  localparam int DATA_W       = 32;
  localparam int REG_W        = 5;

  typedef enum logic [1:0] {
    TYPE_ALU    = 2'b00,
    TYPE_BRANCH = 2'b01,
    TYPE_LOAD   = 2'b10,
    TYPE_STORE  = 2'b11
  } rob_type_e;

endpackage

// File: rtl/rob_if.sv
// Reorder-buffer bus: issue, result broadcasts, operand queries, retire and flush.
// master = decoder/execution side, slave = the ROB itself.
interface rob_if
  import rob_pkg::*;
#(
  parameter int ROB_BIT = ROB_BIT_DEF
);

  logic               issue_valid;
  logic [REG_W-1:0]   issue_rd;
  logic [1:0]         issue_type;
  logic               issue_pred_taken;
  logic [DATA_W-1:0]  issue_alt_pc;
  logic [ROB_BIT-1:0] issue_entry;
  logic               full;

  logic               alu_ready;
  logic [ROB_BIT-1:0] alu_rob_entry;
  logic [DATA_W-1:0]  alu_value;
  logic               lsb_ready;
  logic [ROB_BIT-1:0] lsb_rob_entry;
  logic [DATA_W-1:0]  lsb_value;

  logic [ROB_BIT-1:0] q1_entry;
  logic [ROB_BIT-1:0] q2_entry;
  logic               q1_ready;
  logic               q2_ready;
  logic [DATA_W-1:0]  q1_value;
  logic [DATA_W-1:0]  q2_value;

  logic               commit_valid;
  logic [REG_W-1:0]   commit_rd;
  logic [DATA_W-1:0]  commit_value;
  logic [ROB_BIT-1:0] commit_entry;
  logic               commit_store;
  logic               clear_up;
  logic [DATA_W-1:0]  redirect_pc;

  modport master (
    output issue_valid, issue_rd, issue_type, issue_pred_taken, issue_alt_pc,
    input  issue_entry, full,
    output alu_ready, alu_rob_entry, alu_value,
    output lsb_ready, lsb_rob_entry, lsb_value,
    output q1_entry, q2_entry,
    input  q1_ready, q2_ready, q1_value, q2_value,
    input  commit_valid, commit_rd, commit_value, commit_entry, commit_store,
    input  clear_up, redirect_pc
  );

  modport slave (
    input  issue_valid, issue_rd, issue_type, issue_pred_taken, issue_alt_pc,
    output issue_entry, full,
    input  alu_ready, alu_rob_entry, alu_value,
    input  lsb_ready, lsb_rob_entry, lsb_value,
    input  q1_entry, q2_entry,
    output q1_ready, q2_ready, q1_value, q2_value,
    output commit_valid, commit_rd, commit_value, commit_entry, commit_store,
    output clear_up, redirect_pc
  );

endinterface

// File: rtl/rob_query.sv
// Combinational operand lookup into the ROB entry array.
// With ROB_CDB_BYPASS_EN defined, a same-cycle broadcast is forwarded (lsb over alu).
module rob_query
  import rob_pkg::*;
#(
  parameter int ROB_BIT = ROB_BIT_DEF
) (
  input  logic                                   rdy_in,
  input  logic [(1<<ROB_BIT)-1:0]                busy,
  input  logic [(1<<ROB_BIT)-1:0]                ready,
  input  logic [(1<<ROB_BIT)-1:0][DATA_W-1:0]    value,
  input  logic                                   alu_ready,
  input  logic [ROB_BIT-1:0]                     alu_rob_entry,
  input  logic [DATA_W-1:0]                      alu_value,
  input  logic                                   lsb_ready,
  input  logic [ROB_BIT-1:0]                     lsb_rob_entry,
  input  logic [DATA_W-1:0]                      lsb_value,
  input  logic [ROB_BIT-1:0]                     q_entry,
  output logic                                   q_ready,
  output logic [DATA_W-1:0]                      q_value
);

  always_comb begin
    q_ready = !busy[q_entry] || ready[q_entry];
    q_value = value[q_entry];
`ifdef ROB_CDB_BYPASS_EN
    // Forward only what the entry array would actually capture at the next edge.
    if (rdy_in && busy[q_entry]) begin
      if (lsb_ready && (lsb_rob_entry == q_entry)) begin
        q_ready = 1'b1;
        q_value = lsb_value;
      end else if (alu_ready && (alu_rob_entry == q_entry)) begin
        q_ready = 1'b1;
        q_value = alu_value;
      end
    end
`endif
  end

`ifndef ROB_CDB_BYPASS_EN
  logic unused_bcast;
  assign unused_bcast = ^{rdy_in, alu_ready, alu_rob_entry, alu_value,
                          lsb_ready, lsb_rob_entry, lsb_value};
`endif

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order retire of out-of-order results, branch-mispredict flush.
// Optional macro ROB_CDB_BYPASS_EN forwards same-cycle broadcasts to operand queries.
module rob
  import rob_pkg::*;
#(
  parameter int ROB_BIT = ROB_BIT_DEF
) (
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  rdy_in,
  rob_if.slave  bus
);

  localparam int ROB_SIZE = 2 ** ROB_BIT;
  localparam logic [ROB_BIT:0] FULL_CNT = {1'b1, {ROB_BIT{1'b0}}};

  logic [ROB_BIT-1:0]                    head_q, head_d, tail_q, tail_d;
  logic [ROB_BIT:0]                      count_q, count_d;
  logic [ROB_SIZE-1:0]                   busy_q, busy_d, ready_q, ready_d;
  logic [ROB_SIZE-1:0]                   pred_q, pred_d;
  logic [ROB_SIZE-1:0][REG_W-1:0]        rd_q, rd_d;
  logic [ROB_SIZE-1:0][1:0]              type_q, type_d;
  logic [ROB_SIZE-1:0][DATA_W-1:0]       alt_pc_q, alt_pc_d, value_q, value_d;

  logic                                  commit_valid_q, commit_valid_d;
  logic [REG_W-1:0]                      commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0]                     commit_value_q, commit_value_d;
  logic [ROB_BIT-1:0]                    commit_entry_q, commit_entry_d;
  logic                                  commit_store_q, commit_store_d;
  logic                                  clear_up_q, clear_up_d;
  logic [DATA_W-1:0]                     redirect_pc_q, redirect_pc_d;

  logic full, issue_fire, commit_fire, mispredict;

  always_comb begin
    full        = (count_q == FULL_CNT);
    // Full is judged on the pre-commit count, so a slot freed this cycle is not reusable yet.
    issue_fire  = bus.issue_valid && !full && rdy_in && !clear_up_q;
    commit_fire = rdy_in && busy_q[head_q] && ready_q[head_q];
    mispredict  = commit_fire && (type_q[head_q] == TYPE_BRANCH) &&
                  (value_q[head_q][0] != pred_q[head_q]);

    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    busy_d         = busy_q;
    ready_d        = ready_q;
    pred_d         = pred_q;
    rd_d           = rd_q;
    type_d         = type_q;
    alt_pc_d       = alt_pc_q;
    value_d        = value_q;
    commit_valid_d = 1'b0;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    commit_entry_d = commit_entry_q;
    commit_store_d = commit_store_q;
    clear_up_d     = 1'b0;
    redirect_pc_d  = redirect_pc_q;

    if (rdy_in) begin
      if (bus.alu_ready && busy_q[bus.alu_rob_entry]) begin
        ready_d[bus.alu_rob_entry] = 1'b1;
        value_d[bus.alu_rob_entry] = bus.alu_value;
      end
      // Applied second so a same-entry lsb result overrides the alu one.
      if (bus.lsb_ready && busy_q[bus.lsb_rob_entry]) begin
        ready_d[bus.lsb_rob_entry] = 1'b1;
        value_d[bus.lsb_rob_entry] = bus.lsb_value;
      end

      if (issue_fire) begin
        busy_d[tail_q]   = 1'b1;
        ready_d[tail_q]  = 1'b0;
        rd_d[tail_q]     = bus.issue_rd;
        type_d[tail_q]   = bus.issue_type;
        pred_d[tail_q]   = bus.issue_pred_taken;
        alt_pc_d[tail_q] = bus.issue_alt_pc;
        tail_d           = tail_q + 1'b1;
      end

      if (commit_fire) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + 1'b1;
        commit_valid_d = 1'b1;
        commit_rd_d    = rd_q[head_q];
        commit_value_d = value_q[head_q];
        commit_entry_d = head_q;
        commit_store_d = (type_q[head_q] == TYPE_STORE);
      end

      case ({issue_fire, commit_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      // A mispredicted branch squashes everything younger, including a same-cycle issue.
      if (mispredict) begin
        commit_rd_d   = '0;
        clear_up_d    = 1'b1;
        redirect_pc_d = alt_pc_q[head_q];
        busy_d        = '0;
        head_d        = '0;
        tail_d        = '0;
        count_d       = '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      ready_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_entry_q <= '0;
      commit_store_q <= 1'b0;
      clear_up_q     <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      commit_entry_q <= commit_entry_d;
      commit_store_q <= commit_store_d;
      clear_up_q     <= clear_up_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  // Entry payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk_in) begin
    pred_q   <= pred_d;
    rd_q     <= rd_d;
    type_q   <= type_d;
    alt_pc_q <= alt_pc_d;
    value_q  <= value_d;
  end

  logic              q1_ready, q2_ready;
  logic [DATA_W-1:0] q1_value, q2_value;

  rob_query #(.ROB_BIT(ROB_BIT)) u_query1 (
    .rdy_in        (rdy_in),
    .busy          (busy_q),
    .ready         (ready_q),
    .value         (value_q),
    .alu_ready     (bus.alu_ready),
    .alu_rob_entry (bus.alu_rob_entry),
    .alu_value     (bus.alu_value),
    .lsb_ready     (bus.lsb_ready),
    .lsb_rob_entry (bus.lsb_rob_entry),
    .lsb_value     (bus.lsb_value),
    .q_entry       (bus.q1_entry),
    .q_ready       (q1_ready),
    .q_value       (q1_value)
  );

  rob_query #(.ROB_BIT(ROB_BIT)) u_query2 (
    .rdy_in        (rdy_in),
    .busy          (busy_q),
    .ready         (ready_q),
    .value         (value_q),
    .alu_ready     (bus.alu_ready),
    .alu_rob_entry (bus.alu_rob_entry),
    .alu_value     (bus.alu_value),
    .lsb_ready     (bus.lsb_ready),
    .lsb_rob_entry (bus.lsb_rob_entry),
    .lsb_value     (bus.lsb_value),
    .q_entry       (bus.q2_entry),
    .q_ready       (q2_ready),
    .q_value       (q2_value)
  );

  assign bus.issue_entry  = tail_q;
  assign bus.full         = full;
  assign bus.q1_ready     = q1_ready;
  assign bus.q2_ready     = q2_ready;
  assign bus.q1_value     = q1_value;
  assign bus.q2_value     = q2_value;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_rd    = commit_rd_q;
  assign bus.commit_value = commit_value_q;
  assign bus.commit_entry = commit_entry_q;
  assign bus.commit_store = commit_store_q;
  assign bus.clear_up     = clear_up_q;
  assign bus.redirect_pc  = redirect_pc_q;

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: vector table for issue/broadcast/commit ordering,
// plus hand sequences for full/wrap, mispredict flush, query bypass and rdy_in stall.
module tb_rob;
  import rob_pkg::*;

  localparam int RB = 3;
`ifdef ROB_CDB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  rob_if #(.ROB_BIT(RB)) bus ();

  rob #(.ROB_BIT(RB)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        iv;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic        av;
    logic [2:0]  ae;
    logic [31:0] aval;
    logic        lv;
    logic [2:0]  le;
    logic [31:0] lval;
    logic [2:0]  q1e;
    logic [2:0]  e_ie;
    logic        e_q1r;
    logic [31:0] e_q1v;
    logic        e_cv;
    logic [4:0]  e_rd;
    logic [31:0] e_val;
    logic [2:0]  e_entry;
    logic        e_store;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic vec_t mk(logic iv, logic [1:0] typ, logic [4:0] rd,
                              logic av, logic [2:0] ae, logic [31:0] aval,
                              logic lv, logic [2:0] le, logic [31:0] lval,
                              logic [2:0] q1e, logic [2:0] e_ie, logic e_q1r, logic [31:0] e_q1v,
                              logic e_cv, logic [4:0] e_rd, logic [31:0] e_val,
                              logic [2:0] e_entry, logic e_store);
    vec_t v;
    v.iv = iv; v.typ = typ; v.rd = rd;
    v.av = av; v.ae = ae; v.aval = aval;
    v.lv = lv; v.le = le; v.lval = lval;
    v.q1e = q1e; v.e_ie = e_ie; v.e_q1r = e_q1r; v.e_q1v = e_q1v;
    v.e_cv = e_cv; v.e_rd = e_rd; v.e_val = e_val; v.e_entry = e_entry; v.e_store = e_store;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.issue_valid      = 1'b0;
    bus.issue_rd         = '0;
    bus.issue_type       = TYPE_ALU;
    bus.issue_pred_taken = 1'b0;
    bus.issue_alt_pc     = '0;
    bus.alu_ready        = 1'b0;
    bus.alu_rob_entry    = '0;
    bus.alu_value        = '0;
    bus.lsb_ready        = 1'b0;
    bus.lsb_rob_entry    = '0;
    bus.lsb_value        = '0;
    bus.q1_entry         = '0;
    bus.q2_entry         = '0;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [1:0] typ, input logic [4:0] rd,
                       input logic pred, input logic [31:0] alt);
    bus.issue_valid      = 1'b1;
    bus.issue_type       = typ;
    bus.issue_rd         = rd;
    bus.issue_pred_taken = pred;
    bus.issue_alt_pc     = alt;
  endtask

  task automatic do_reset();
    idle_inputs();
    rdy_in = 1'b1;
    rst_in = 1'b1;
    issue(TYPE_ALU, 5'd31, 1'b0, 32'h0);
    step();
    step();
    chk("rst_issue_entry", 32'(bus.issue_entry), 32'h0);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_commit_valid", 32'(bus.commit_valid), 32'h0);
    chk("rst_clear_up", 32'(bus.clear_up), 32'h0);
    chk("rst_commit_store", 32'(bus.commit_store), 32'h0);
    chk("rst_commit_rd", 32'(bus.commit_rd), 32'h0);
    chk("rst_commit_entry", 32'(bus.commit_entry), 32'h0);
    chk("rst_commit_value", bus.commit_value, 32'h0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
    chk("rst_q1_ready", 32'(bus.q1_ready), 32'h1);
    rst_in = 1'b0;
    idle_inputs();
  endtask

  initial begin
    vecs[0]  = mk(1, TYPE_ALU,   5'd1, 0, 0, 0,         0, 0, 0,         7, 0, 1, 0,        0, 0, 0,         0, 0);
    vecs[1]  = mk(1, TYPE_ALU,   5'd2, 0, 0, 0,         0, 0, 0,         7, 1, 1, 0,        0, 0, 0,         0, 0);
    vecs[2]  = mk(1, TYPE_ALU,   5'd3, 0, 0, 0,         0, 0, 0,         7, 2, 1, 0,        0, 0, 0,         0, 0);
    vecs[3]  = mk(0, TYPE_ALU,   5'd0, 1, 1, 32'h11,    0, 0, 0,         2, 3, 0, 0,        0, 0, 0,         0, 0);
    vecs[4]  = mk(0, TYPE_ALU,   5'd0, 1, 0, 32'h55,    0, 0, 0,         1, 3, 1, 32'h11,   0, 0, 0,         0, 0);
    vecs[5]  = mk(0, TYPE_ALU,   5'd0, 0, 0, 0,         0, 0, 0,         7, 3, 1, 0,        1, 1, 32'h55,    0, 0);
    vecs[6]  = mk(0, TYPE_ALU,   5'd0, 0, 0, 0,         0, 0, 0,         7, 3, 1, 0,        1, 2, 32'h11,    1, 0);
    vecs[7]  = mk(0, TYPE_ALU,   5'd0, 0, 0, 0,         0, 0, 0,         7, 3, 1, 0,        0, 0, 0,         0, 0);
    vecs[8]  = mk(0, TYPE_ALU,   5'd0, 1, 2, 32'h99,    1, 2, 32'h77,    7, 3, 1, 0,        0, 0, 0,         0, 0);
    vecs[9]  = mk(0, TYPE_ALU,   5'd0, 0, 0, 0,         0, 0, 0,         7, 3, 1, 0,        1, 3, 32'h77,    2, 0);
    vecs[10] = mk(1, TYPE_STORE, 5'd4, 0, 0, 0,         0, 0, 0,         7, 3, 1, 0,        0, 0, 0,         0, 0);
    vecs[11] = mk(1, TYPE_ALU,   5'd5, 0, 0, 0,         1, 3, 32'h1234,  7, 4, 1, 0,        0, 0, 0,         0, 0);
    vecs[12] = mk(0, TYPE_ALU,   5'd0, 1, 6, 32'hDEAD,  0, 0, 0,         7, 5, 1, 0,        1, 4, 32'h1234,  3, 1);
    vecs[13] = mk(0, TYPE_ALU,   5'd0, 1, 4, 32'hA,     0, 0, 0,         7, 5, 1, 0,        0, 0, 0,         0, 0);
    vecs[14] = mk(1, TYPE_ALU,   5'd6, 0, 0, 0,         0, 0, 0,         7, 5, 1, 0,        1, 5, 32'hA,     4, 0);
    vecs[15] = mk(0, TYPE_ALU,   5'd0, 0, 0, 0,         0, 0, 0,         5, 6, 0, 0,        0, 0, 0,         0, 0);

    do_reset();

    for (int i = 0; i < NV; i++) begin
      bus.issue_valid      = vecs[i].iv;
      bus.issue_type       = vecs[i].typ;
      bus.issue_rd         = vecs[i].rd;
      bus.issue_pred_taken = 1'b0;
      bus.issue_alt_pc     = '0;
      bus.alu_ready        = vecs[i].av;
      bus.alu_rob_entry    = vecs[i].ae;
      bus.alu_value        = vecs[i].aval;
      bus.lsb_ready        = vecs[i].lv;
      bus.lsb_rob_entry    = vecs[i].le;
      bus.lsb_value        = vecs[i].lval;
      bus.q1_entry         = vecs[i].q1e;
      #1;
      chk($sformatf("v%0d_issue_entry", i), 32'(bus.issue_entry), 32'(vecs[i].e_ie));
      chk($sformatf("v%0d_full", i), 32'(bus.full), 32'h0);
      chk($sformatf("v%0d_q1_ready", i), 32'(bus.q1_ready), 32'(vecs[i].e_q1r));
      if (vecs[i].e_q1v != 32'h0)
        chk($sformatf("v%0d_q1_value", i), bus.q1_value, vecs[i].e_q1v);
      step();
      chk($sformatf("v%0d_commit_valid", i), 32'(bus.commit_valid), 32'(vecs[i].e_cv));
      if (vecs[i].e_cv) begin
        chk($sformatf("v%0d_commit_rd", i), 32'(bus.commit_rd), 32'(vecs[i].e_rd));
        chk($sformatf("v%0d_commit_value", i), bus.commit_value, vecs[i].e_val);
        chk($sformatf("v%0d_commit_entry", i), 32'(bus.commit_entry), 32'(vecs[i].e_entry));
        chk($sformatf("v%0d_commit_store", i), 32'(bus.commit_store), 32'(vecs[i].e_store));
      end
    end
    idle_inputs();

    // Fill, overflow attempt, and issue blocked in the commit cycle while full.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      issue(TYPE_ALU, 5'(i + 1), 1'b0, 32'h0);
      step();
    end
    idle_inputs();
    #1;
    chk("fill_full", 32'(bus.full), 32'h1);
    chk("fill_tail_wrapped", 32'(bus.issue_entry), 32'h0);
    issue(TYPE_ALU, 5'd20, 1'b0, 32'h0);
    step();
    chk("overflow_ignored_entry", 32'(bus.issue_entry), 32'h0);
    chk("overflow_full", 32'(bus.full), 32'h1);
    idle_inputs();
    bus.alu_ready = 1'b1; bus.alu_rob_entry = 3'd0; bus.alu_value = 32'hC0;
    step();
    idle_inputs();
    issue(TYPE_ALU, 5'd21, 1'b0, 32'h0);
    step();
    chk("full_commit_valid", 32'(bus.commit_valid), 32'h1);
    chk("full_commit_value", bus.commit_value, 32'hC0);
    chk("full_commit_entry", 32'(bus.commit_entry), 32'h0);
    chk("full_issue_blocked", 32'(bus.issue_entry), 32'h0);
    chk("after_commit_not_full", 32'(bus.full), 32'h0);
    issue(TYPE_ALU, 5'd9, 1'b0, 32'h0);
    step();
    chk("refill_full", 32'(bus.full), 32'h1);
    chk("refill_tail", 32'(bus.issue_entry), 32'h1);
    chk("refill_no_commit", 32'(bus.commit_valid), 32'h0);
    idle_inputs();

    // Mispredicted branch flushes; issue during the flush cycle is dropped.
    do_reset();
    issue(TYPE_BRANCH, 5'd0, 1'b1, 32'h100);
    step();
    issue(TYPE_ALU, 5'd7, 1'b0, 32'h0);
    step();
    idle_inputs();
    bus.alu_ready = 1'b1; bus.alu_rob_entry = 3'd0; bus.alu_value = 32'h0;
    step();
    idle_inputs();
    step();
    chk("mp_commit_valid", 32'(bus.commit_valid), 32'h1);
    chk("mp_clear_up", 32'(bus.clear_up), 32'h1);
    chk("mp_redirect_pc", bus.redirect_pc, 32'h100);
    chk("mp_commit_rd", 32'(bus.commit_rd), 32'h0);
    chk("mp_commit_entry", 32'(bus.commit_entry), 32'h0);
    issue(TYPE_ALU, 5'd9, 1'b0, 32'h0);
    step();
    chk("flush_clear_up_pulse", 32'(bus.clear_up), 32'h0);
    chk("flush_commit_valid", 32'(bus.commit_valid), 32'h0);
    chk("flush_issue_dropped", 32'(bus.issue_entry), 32'h0);
    chk("flush_full", 32'(bus.full), 32'h0);
    idle_inputs();
    bus.q1_entry = 3'd1;
    #1;
    chk("flush_entry1_free", 32'(bus.q1_ready), 32'h1);
    issue(TYPE_BRANCH, 5'd8, 1'b0, 32'h200);
    step();
    idle_inputs();
    bus.alu_ready = 1'b1; bus.alu_rob_entry = 3'd0; bus.alu_value = 32'h0;
    step();
    idle_inputs();
    step();
    chk("bp_ok_commit_valid", 32'(bus.commit_valid), 32'h1);
    chk("bp_ok_clear_up", 32'(bus.clear_up), 32'h0);
    chk("bp_ok_commit_rd", 32'(bus.commit_rd), 32'h8);
    chk("bp_ok_tail", 32'(bus.issue_entry), 32'h1);

    // Operand query sees a same-cycle broadcast only with the bypass build.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(TYPE_ALU, 5'(i + 1), 1'b0, 32'h0);
      step();
    end
    idle_inputs();
    bus.q1_entry = 3'd2;
    bus.q2_entry = 3'd2;
    bus.alu_ready = 1'b1; bus.alu_rob_entry = 3'd2; bus.alu_value = 32'hAB;
    #1;
    chk("byp_q1_ready", 32'(bus.q1_ready), 32'(BYP));
    chk("byp_q2_ready", 32'(bus.q2_ready), 32'(BYP));
    if (BYP) chk("byp_q1_value", bus.q1_value, 32'hAB);
    step();
    bus.alu_ready = 1'b0;
    #1;
    chk("stored_q1_ready", 32'(bus.q1_ready), 32'h1);
    chk("stored_q1_value", bus.q1_value, 32'hAB);
    chk("stored_q2_value", bus.q2_value, 32'hAB);
    idle_inputs();

    // rdy_in low stalls a ready head; retire follows the first edge with rdy_in high.
    do_reset();
    issue(TYPE_ALU, 5'd10, 1'b0, 32'h0);
    step();
    idle_inputs();
    bus.alu_ready = 1'b1; bus.alu_rob_entry = 3'd0; bus.alu_value = 32'h5A;
    step();
    idle_inputs();
    rdy_in = 1'b0;
    issue(TYPE_ALU, 5'd11, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_commit_valid", i), 32'(bus.commit_valid), 32'h0);
      chk($sformatf("stall%0d_no_issue", i), 32'(bus.issue_entry), 32'h1);
    end
    idle_inputs();
    rdy_in = 1'b1;
    step();
    chk("resume_commit_valid", 32'(bus.commit_valid), 32'h1);
    chk("resume_commit_value", bus.commit_value, 32'h5A);
    chk("resume_commit_rd", 32'(bus.commit_rd), 32'hA);
    step();
    chk("resume_single_pulse", 32'(bus.commit_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameter ROB_BIT, default 3, log2 of entry count; ROB_SIZE = 2**ROB_BIT.
REQ-002 clk_in  input  1  system clock; all state changes on posedge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 rdy_in  input  1  ready; low freezes all state.
REQ-005 issue_valid  input  1  decoder requests allocation this cycle.
REQ-006 issue_rd, issue_type, issue_pred_taken  input  5/2/1  destination reg, kind (00 ALU, 01 BRANCH, 10 LOAD, 11 STORE), predicted direction.
REQ-007 issue_alt_pc  input  32  PC of the non-predicted path.
REQ-008 issue_entry  output  ROB_BIT  index allocated on issue (current tail).
REQ-009 full  output  1  no free entry; combinational.
REQ-010 alu_ready, alu_rob_entry, alu_value  input  1/ROB_BIT/32  ALU result broadcast; for BRANCH, alu_value[0] is actual taken.
REQ-011 lsb_ready, lsb_rob_entry, lsb_value  input  1/ROB_BIT/32  load/store completion broadcast.
REQ-012 q1_entry, q2_entry  input  ROB_BIT  operand dependency lookups; q1_ready, q2_ready output 1; q1_value, q2_value output 32.
REQ-013 commit_valid, commit_rd, commit_value, commit_entry, commit_store  output  1/5/32/ROB_BIT/1  registered retire port.
REQ-014 clear_up  output  1  registered flush pulse; redirect_pc output 32 valid with it.

Function
REQ-015 Circular buffer: head, tail, count; full = (count == ROB_SIZE); empty = (count == 0).
REQ-016 Issue accepted when issue_valid && !full && rdy_in && !clear_up: entry at tail gets busy=1, ready=0, fields stored; tail increments mod ROB_SIZE (wrap from ROB_SIZE-1 to 0).
REQ-017 issue_valid while full is ignored; no state change, no error.
REQ-018 Broadcast: alu_ready (resp. lsb_ready) on a busy entry sets ready=1 and stores value; both on same entry same cycle, lsb wins; broadcast to non-busy entry ignored.
REQ-019 Commit: if head busy and ready, next cycle commit_valid=1 for exactly one cycle with that entry's rd, value, index, commit_store=(type==STORE); head increments; entry busy cleared. At most one commit per cycle.
REQ-020 Simultaneous issue and commit: count unchanged; both take effect. Issue into just-freed slot in same cycle not allowed (full evaluated before commit).
REQ-021 BRANCH commit with value[0] != pred_taken: commit_valid=1 and clear_up=1 same cycle, redirect_pc = stored alt_pc; commit_rd forced 0.
REQ-022 Cycle after clear_up: head=tail=count=0, all busy=0; issue in clear_up cycle discarded.
REQ-023 Query: qN_ready=1 iff entry busy and ready (or not busy); qN_value = stored value; combinational.
REQ-024 rdy_in low: no issue, broadcast, commit; commit_valid and clear_up driven 0.
REQ-025 Latency: broadcast to commit_valid minimum 2 cycles (capture, then commit).

Reset
REQ-026 On rst_in: head, tail, count 0; all busy/ready 0; commit_valid, clear_up, commit_store 0; commit_rd, commit_entry 0; commit_value, redirect_pc 32'h0; full 0.
REQ-027 Reset overrides rdy_in and any in-flight issue, broadcast or commit.

Configuration
REQ-028 ROB_CDB_BYPASS_EN defined: qN_ready/qN_value also reflect a same-cycle alu/lsb broadcast matching qN_entry (lsb priority).
REQ-029 ROB_CDB_BYPASS_EN undefined: query sees stored state only; broadcast visible next cycle.

Structure
REQ-030 ROB_BIT, ROB_SIZE, type encodings live in shared Const.v.
REQ-031 One sub-module Rob_query (combinational lookup incl. bypass), instanced twice.

Verification
REQ-032 Reset, issue 3 ALU (rd 1,2,3) -> issue_entry 0,1,2; count 3; full 0.
REQ-033 Broadcast entry 1 then entry 0 value 0x55 -> commit entry 0 value 0x55, then entry 1, in order.
REQ-034 Fill 8 entries, issue again -> ignored, full 1; commit 1 + issue same cycle -> tail wraps to 0, full stays 1.
REQ-035 BRANCH pred 1, alt_pc 0x100, alu_value 0 -> clear_up=1, redirect_pc 0x100; next cycle count 0, full 0.
REQ-036 q1_entry=2, broadcast entry 2 value 0xAB same cycle -> q1_ready=1/q1_value 0xAB with ROB_CDB_BYPASS_EN, q1_ready=0 without.
REQ-037 rdy_in low 3 cycles during ready head -> no commit; resumes one cycle after rdy_in high.
